// File: rtl/nebula_axil_master.sv
// Single-outstanding AXI-Lite master: converts a request/response command stream into
// AXI-Lite transactions, with a bus timeout and a saturating error counter.
module nebula_axil_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                m_aw_valid_o,
  input  logic                m_aw_ready_i,
  output logic [ADDR_W-1:0]   m_aw_addr_o,
  output logic [DATA_W-1:0]   m_aw_data_o,
  output logic [DATA_W/8-1:0] m_aw_strb_o,
  output logic                m_ar_valid_o,
  input  logic                m_ar_ready_i,
  output logic [ADDR_W-1:0]   m_ar_addr_o,
  input  logic                m_b_valid_i,
  output logic                m_b_ready_o,
  input  logic [1:0]          m_b_resp_i,
  input  logic                m_r_valid_i,
  output logic                m_r_ready_o,
  input  logic [DATA_W-1:0]   m_r_data_i,
  input  logic [1:0]          m_r_resp_i,
  output logic [15:0]         err_cnt_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                expire;
  logic                enter_err;

  assign expire = (TIMEOUT != 0) && (timer_q == TLAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    enter_err = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req_valid_i) begin
          addr_d  = req_addr_i & ~ADDR_W'(3);
          wdata_d = req_wdata_i;
          strb_d  = req_strb_i;
          state_d = req_we_i ? WR_ADDR : RD_ADDR;
        end
      end
      // A handshake in the expiry cycle takes priority over the timeout.
      WR_ADDR, RD_ADDR: begin
        timer_d = timer_q + 1'b1;
        if ((state_q == WR_ADDR) ? m_aw_ready_i : m_ar_ready_i) begin
          state_d = (state_q == WR_ADDR) ? WR_RESP : RD_RESP;
        end else if (expire) begin
          state_d   = DONE;
          rdata_d   = TMO_DATA;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          enter_err = 1'b1;
        end
      end
      WR_RESP: begin
        timer_d = timer_q + 1'b1;
        if (m_b_valid_i) begin
          state_d   = DONE;
          rdata_d   = '0;
          err_d     = (m_b_resp_i != 2'b00);
          tmo_d     = 1'b0;
          enter_err = (m_b_resp_i != 2'b00);
        end else if (expire) begin
          state_d   = DONE;
          rdata_d   = TMO_DATA;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          enter_err = 1'b1;
        end
      end
      RD_RESP: begin
        timer_d = timer_q + 1'b1;
        if (m_r_valid_i) begin
          state_d   = DONE;
          rdata_d   = m_r_data_i;
          err_d     = (m_r_resp_i != 2'b00);
          tmo_d     = 1'b0;
          enter_err = (m_r_resp_i != 2'b00);
        end else if (expire) begin
          state_d   = DONE;
          rdata_d   = TMO_DATA;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          enter_err = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (enter_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      timer_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Everything is decoded from the state register so an async reset clears the bus at once.
  assign req_ready_o   = (state_q == IDLE);
  assign m_aw_valid_o  = (state_q == WR_ADDR);
  assign m_ar_valid_o  = (state_q == RD_ADDR);
  assign m_b_ready_o   = (state_q == WR_RESP);
  assign m_r_ready_o   = (state_q == RD_RESP);
  assign rsp_valid_o   = (state_q == DONE);

  assign m_aw_addr_o   = m_aw_valid_o ? addr_q  : '0;
  assign m_aw_data_o   = m_aw_valid_o ? wdata_q : '0;
  assign m_aw_strb_o   = m_aw_valid_o ? strb_q  : '0;
  assign m_ar_addr_o   = m_ar_valid_o ? addr_q  : '0;
  assign rsp_rdata_o   = rsp_valid_o  ? rdata_q : '0;
  assign rsp_err_o     = rsp_valid_o  & err_q;
  assign rsp_timeout_o = rsp_valid_o  & tmo_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_nebula_axil_master.sv
// Directed bench for nebula_axil_master: the bench plays command source and AXI-Lite slave,
// and each scenario task compares against hand-computed values.
module tb_nebula_axil_master;

  logic        clk;
  logic        rst;
  logic        reqValid, reqReady, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqStrb;
  logic        rspValid, rspReady, rspErr, rspTimeout;
  logic [31:0] rspRdata;
  logic        awValid, awReady, arValid, arReady;
  logic [31:0] awAddr, awData, arAddr;
  logic [3:0]  awStrb;
  logic        bValid, bReady, rValid, rReady;
  logic [1:0]  bResp, rResp;
  logic [31:0] rData;
  logic [15:0] errCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          beats;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          stable;
    bit          reqReadyLow;
    int          rspCycle;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } txn_t;

  nebula_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_strb_i(reqStrb),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata),
    .rsp_err_o(rspErr), .rsp_timeout_o(rspTimeout),
    .m_aw_valid_o(awValid), .m_aw_ready_i(awReady), .m_aw_addr_o(awAddr),
    .m_aw_data_o(awData), .m_aw_strb_o(awStrb),
    .m_ar_valid_o(arValid), .m_ar_ready_i(arReady), .m_ar_addr_o(arAddr),
    .m_b_valid_i(bValid), .m_b_ready_o(bReady), .m_b_resp_i(bResp),
    .m_r_valid_i(rValid), .m_r_ready_o(rReady), .m_r_data_i(rData), .m_r_resp_i(rResp),
    .err_cnt_o(errCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one command and acts as the slave; addrWait cycles of ready-low before the
  // address beat, and answer=0 means the slave never responds. Returns at the DONE cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int addrWait, input bit answer,
                               input logic [1:0] resp, input logic [31:0] slvData,
                               output txn_t t);
    int waitCnt;
    bit seen;
    logic [31:0] pa;
    t = '{default: 0};
    t.stable = 1'b1;
    t.reqReadyLow = 1'b1;
    t.rspCycle = -1;
    waitCnt = 0;
    seen = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqStrb = strb;
    @(negedge clk);
    reqValid = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (rspValid) begin
        t.rspCycle = cyc;
        t.rdata = rspRdata;
        t.err = rspErr;
        t.tmo = rspTimeout;
        break;
      end
      if (reqReady) t.reqReadyLow = 1'b0;
      awReady = 1'b0; arReady = 1'b0; bValid = 1'b0; rValid = 1'b0;
      if (awValid || arValid) begin
        pa = awValid ? awAddr : arAddr;
        if (!seen) begin
          t.addr = pa; t.data = awData; t.strb = awStrb; seen = 1'b1;
        end else if (pa !== t.addr || awData !== t.data || awStrb !== t.strb) begin
          t.stable = 1'b0;
        end
        if (waitCnt >= addrWait) begin
          awReady = awValid; arReady = arValid;
          t.beats++;
        end
        waitCnt++;
      end
      if (answer && (bReady || rReady)) begin
        bValid = bReady; rValid = rReady;
        bResp = resp; rResp = resp; rData = slvData;
      end
      @(negedge clk);
    end
    awReady = 1'b0; arReady = 1'b0; bValid = 1'b0; rValid = 1'b0;
  endtask

  task automatic finishResponse();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", reqReady); end
    checks++; if ({awValid, arValid, bReady, rReady, rspValid} !== 5'b0) begin errors++; $display("[TB] FAIL reset_handshakes got %b want 00000", {awValid, arValid, bReady, rReady, rspValid}); end
    checks++; if ({awAddr, awData, arAddr, rspRdata} !== 128'h0) begin errors++; $display("[TB] FAIL reset_payloads got %h want 0", {awAddr, awData, arAddr, rspRdata}); end
    checks++; if (errCnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_err_cnt got %h want 0000", errCnt); end
    rst = 1'b0;
  endtask

  task automatic test_write_basic();
    txn_t t;
    applyStimulus(1'b1, 32'h0, 32'd12, 4'hF, 0, 1'b1, 2'b00, 32'h0, t);
    checks++; if (t.beats !== 1) begin errors++; $display("[TB] FAIL wr_beats got %0d want 1", t.beats); end
    checks++; if (t.addr !== 32'h0 || t.data !== 32'd12 || t.strb !== 4'hF) begin errors++; $display("[TB] FAIL wr_beat got %h/%h/%h want 0/c/f", t.addr, t.data, t.strb); end
    checks++; if (t.rspCycle !== 3) begin errors++; $display("[TB] FAIL wr_latency got %0d want 3", t.rspCycle); end
    checks++; if ({t.err, t.tmo} !== 2'b00 || t.rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rsp got err=%b tmo=%b rdata=%h want 0 0 0", t.err, t.tmo, t.rdata); end
    finishResponse();
    checks++; if (reqReady !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("[TB] FAIL wr_return_idle got rdy=%b vld=%b want 1 0", reqReady, rspValid); end
  endtask

  task automatic test_read_after_write();
    txn_t t;
    applyStimulus(1'b1, 32'h4, 32'hABCD, 4'hF, 0, 1'b1, 2'b00, 32'h0, t);
    checks++; if (t.addr !== 32'h4 || t.data !== 32'hABCD || t.err !== 1'b0) begin errors++; $display("[TB] FAIL raw_write got %h/%h err=%b want 4/abcd 0", t.addr, t.data, t.err); end
    finishResponse();
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b1, 2'b00, 32'hABCD, t);
    checks++; if (t.beats !== 1 || t.addr !== 32'h4) begin errors++; $display("[TB] FAIL raw_ar_beat got beats=%0d addr=%h want 1 4", t.beats, t.addr); end
    checks++; if (t.rdata !== 32'hABCD || t.err !== 1'b0) begin errors++; $display("[TB] FAIL raw_rdata got %h err=%b want abcd 0", t.rdata, t.err); end
    checks++; if (t.rspCycle !== 3) begin errors++; $display("[TB] FAIL raw_latency got %0d want 3", t.rspCycle); end
    finishResponse();
  endtask

  task automatic test_aw_stall();
    txn_t t;
    applyStimulus(1'b1, 32'h10, 32'h5A5A_0001, 4'h6, 5, 1'b1, 2'b00, 32'h0, t);
    checks++; if (t.beats !== 1) begin errors++; $display("[TB] FAIL stall_beats got %0d want 1", t.beats); end
    checks++; if (t.stable !== 1'b1) begin errors++; $display("[TB] FAIL stall_stable got %b want 1", t.stable); end
    checks++; if (t.reqReadyLow !== 1'b1) begin errors++; $display("[TB] FAIL stall_req_ready_low got %b want 1", t.reqReadyLow); end
    checks++; if (t.addr !== 32'h10 || t.data !== 32'h5A5A_0001 || t.strb !== 4'h6) begin errors++; $display("[TB] FAIL stall_payload got %h/%h/%h want 10/5a5a0001/6", t.addr, t.data, t.strb); end
    checks++; if (t.rspCycle !== 8) begin errors++; $display("[TB] FAIL stall_latency got %0d want 8", t.rspCycle); end
    finishResponse();
  endtask

  task automatic test_timeout();
    txn_t t;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1000, 1'b0, 2'b00, 32'h0, t);
    checks++; if (t.rspCycle !== 17) begin errors++; $display("[TB] FAIL tmo_latency got %0d want 17", t.rspCycle); end
    checks++; if ({t.tmo, t.err} !== 2'b11) begin errors++; $display("[TB] FAIL tmo_flags got tmo=%b err=%b want 1 1", t.tmo, t.err); end
    checks++; if (t.rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL tmo_rdata got %h want deadbeef", t.rdata); end
    checks++; if (errCnt !== 16'd1) begin errors++; $display("[TB] FAIL tmo_err_cnt got %0d want 1", errCnt); end
    checks++; if (arValid !== 1'b0 || rReady !== 1'b0) begin errors++; $display("[TB] FAIL tmo_bus_dropped got ar=%b r=%b want 0 0", arValid, rReady); end
    rValid = 1'b1; rData = 32'h1234; rResp = 2'b00;
    @(negedge clk);
    checks++; if (rReady !== 1'b0 || rspRdata !== 32'hDEAD_BEEF || rspValid !== 1'b1) begin errors++; $display("[TB] FAIL tmo_stray_r got rready=%b rdata=%h vld=%b want 0 deadbeef 1", rReady, rspRdata, rspValid); end
    rValid = 1'b0;
    finishResponse();
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL tmo_return_idle got %b want 1", reqReady); end
  endtask

  task automatic test_slverr_unaligned();
    txn_t t;
    applyStimulus(1'b1, 32'h6, 32'h77, 4'hF, 0, 1'b1, 2'b10, 32'h0, t);
    checks++; if (t.addr !== 32'h4) begin errors++; $display("[TB] FAIL unaligned_addr got %h want 4", t.addr); end
    checks++; if ({t.err, t.tmo} !== 2'b10) begin errors++; $display("[TB] FAIL slverr_flags got err=%b tmo=%b want 1 0", t.err, t.tmo); end
    checks++; if (errCnt !== 16'd2) begin errors++; $display("[TB] FAIL slverr_err_cnt got %0d want 2", errCnt); end
    finishResponse();
  endtask

  task automatic test_zero_strb();
    txn_t t;
    applyStimulus(1'b1, 32'h8, 32'hCAFE_F00D, 4'h0, 0, 1'b1, 2'b00, 32'h0, t);
    checks++; if (t.beats !== 1 || t.addr !== 32'h8 || t.strb !== 4'h0 || t.data !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL zero_strb got beats=%0d %h/%h/%h want 1 8/cafef00d/0", t.beats, t.addr, t.data, t.strb); end
    checks++; if (t.err !== 1'b0 || errCnt !== 16'd2) begin errors++; $display("[TB] FAIL zero_strb_err got err=%b cnt=%0d want 0 2", t.err, errCnt); end
    finishResponse();
  endtask

  task automatic test_reset_midflight();
    txn_t t;
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'hC; reqWdata = 32'h1; reqStrb = 4'hF;
    awReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    awReady = 1'b0;
    checks++; if (bReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_wr_resp got bready=%b want 1", bReady); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({awValid, arValid, bReady, rReady, rspValid} !== 5'b0) begin errors++; $display("[TB] FAIL mid_reset_bus got %b want 00000", {awValid, arValid, bReady, rReady, rspValid}); end
    checks++; if (errCnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_err_cnt got %0d want 0", errCnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready got %b want 1", reqReady); end
    applyStimulus(1'b1, 32'h0, 32'h99, 4'hF, 0, 1'b1, 2'b00, 32'h0, t);
    checks++; if (t.rspCycle !== 3 || t.err !== 1'b0) begin errors++; $display("[TB] FAIL mid_recover got cyc=%0d err=%b want 3 0", t.rspCycle, t.err); end
    finishResponse();
  endtask

  initial begin
    rst = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqStrb = '0;
    rspReady = 1'b0;
    awReady = 1'b0; arReady = 1'b0;
    bValid = 1'b0; bResp = 2'b00;
    rValid = 1'b0; rResp = 2'b00; rData = '0;
    test_reset();
    test_write_basic();
    test_read_after_write();
    test_aw_stall();
    test_timeout();
    test_slverr_unaligned();
    test_zero_strb();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
